// File: rtl/wb_regfile.sv
// Sixteen-entry architectural register file with write-through bypass,
// a per-register pending-write scoreboard, and the R15 link-register export.
module wb_regfile #(
  parameter int NREG = 16,
  parameter int DW   = 16,
  parameter int CW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    wb_addr,
  input  logic [DW-1:0] wb,
  input  logic [3:0]    rs_addr,
  input  logic [3:0]    rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  input  logic          issue,
  input  logic [3:0]    issue_addr,
  output logic          rs_busy,
  output logic          rt_busy,
  output logic          stall,
  output logic [DW-1:0] ret_addr,
  output logic          sb_overflow
);

  // Contract with decode: there is no handshake. Decode must not assert
  // issue while stall is high; writeback commits whenever we is high.

  logic [DW-1:0] regs [NREG];
  logic [CW-1:0] cnt  [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      sb_overflow <= 1'b0;
    end else begin
      if (we && wb_addr != 4'd0) regs[wb_addr] <= wb;
      // R0 never counts; an issue and a writeback to the same register cancel.
      for (int r = 1; r < NREG; r++) begin
        if (issue && issue_addr == 4'(r) && !(we && wb_addr == 4'(r))) begin
          if (cnt[r] == '1) sb_overflow <= 1'b1;
          else              cnt[r] <= cnt[r] + CW'(1);
        end else if (we && wb_addr == 4'(r) && !(issue && issue_addr == 4'(r))) begin
          if (cnt[r] != '0) cnt[r] <= cnt[r] - CW'(1);
        end
      end
    end
  end

  function automatic logic [DW-1:0] read_port(input logic [3:0] a);
    if (a == 4'd0)              return '0;
    if (we && wb_addr == a)     return wb;
    return regs[a];
  endfunction

  // The last outstanding write landing this cycle is covered by the bypass.
  function automatic logic busy_port(input logic [3:0] a);
    logic [CW-1:0] c;
    c = cnt[a];
    if (a == 4'd0 || c == '0) return 1'b0;
    if (c == CW'(1) && we && wb_addr == a && !(issue && issue_addr == a)) return 1'b0;
    return 1'b1;
  endfunction

  always_comb begin
    rs_data  = read_port(rs_addr);
    rt_data  = read_port(rt_addr);
    ret_addr = read_port(4'hF);
    rs_busy  = busy_port(rs_addr);
    rt_busy  = busy_port(rt_addr);
    stall    = rs_busy | rt_busy;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a randomized
// issue/writeback stream checked against an array-based reference model.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [3:0]  wb_addr;
  logic [15:0] wb;
  logic [3:0]  rs_addr;
  logic [3:0]  rt_addr;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic        issue;
  logic [3:0]  issue_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic        stall;
  logic [15:0] ret_addr;
  logic        sb_overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural values, pending-write counts, sticky error.
  logic [15:0] m_regs [16];
  int          m_cnt  [16];
  logic        m_ovf;
  // In-flight writebacks in issue order for the random stream.
  logic [3:0]  exp_q [$];

  wb_regfile dut (
    .clk(clk), .rst(rst), .we(we), .wb_addr(wb_addr), .wb(wb),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .issue(issue), .issue_addr(issue_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .stall(stall), .ret_addr(ret_addr), .sb_overflow(sb_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 16'h0;
      m_cnt[i]  = 0;
    end
    m_ovf = 1'b0;
  endfunction

  function automatic void m_update();
    int ia;
    int wa;
    if (rst) begin
      m_reset();
      return;
    end
    ia = issue ? int'(issue_addr) : 0;
    wa = we ? int'(wb_addr) : 0;
    if (wa != 0) m_regs[wa] = wb;
    if (ia != 0 && ia != wa) begin
      if (m_cnt[ia] == 3) m_ovf = 1'b1;
      else                m_cnt[ia] = m_cnt[ia] + 1;
    end
    if (wa != 0 && wa != ia && m_cnt[wa] > 0) m_cnt[wa] = m_cnt[wa] - 1;
  endfunction

  function automatic logic [15:0] exp_rd(input logic [3:0] a);
    if (a == 4'd0) return 16'h0;
    if (we && wb_addr == a) return wb;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [3:0] a);
    if (a == 4'd0 || m_cnt[a] == 0) return 1'b0;
    if (m_cnt[a] == 1 && we && wb_addr == a && !(issue && issue_addr == a)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic idle();
    we = 1'b0; issue = 1'b0; wb = 16'h0; wb_addr = 4'd0; issue_addr = 4'd0;
    rs_addr = 4'd0; rt_addr = 4'd0;
  endtask

  task automatic test_reset();
    idle();
    issue = 1'b1; issue_addr = 4'd3;
    tick();
    issue = 1'b0; we = 1'b1; wb_addr = 4'd3; wb = 16'h1234; rs_addr = 4'd3;
    tick();
    we = 1'b0; issue = 1'b1; issue_addr = 4'd3;
    tick();
    issue = 1'b0;
    #1;
    checks++; if (rs_data !== 16'h1234) begin errors++; $display("FAIL pre_reset_r3 got %h exp %h", rs_data, 16'h1234); end
    checks++; if (rs_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b exp 1", rs_busy); end
    #2 rst = 1'b1; m_reset();
    #1;
    checks++; if (rs_data !== 16'h0) begin errors++; $display("FAIL async_reset_rs got %h exp 0000", rs_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL async_reset_stall got %b exp 0", stall); end
    checks++; if (sb_overflow !== 1'b0) begin errors++; $display("FAIL async_reset_ovf got %b exp 0", sb_overflow); end
    checks++; if (ret_addr !== 16'h0) begin errors++; $display("FAIL async_reset_ret got %h exp 0000", ret_addr); end
    tick();
    rst = 1'b0;
    // Stale writeback after reset must hold the counter at zero.
    we = 1'b1; wb_addr = 4'd3; wb = 16'h5555;
    #1;
    checks++; if (rs_data !== 16'h5555) begin errors++; $display("FAIL post_reset_bypass got %h exp 5555", rs_data); end
    tick();
    we = 1'b0; issue = 1'b1; issue_addr = 4'd3;
    tick();
    issue = 1'b0;
    #1;
    checks++; if (rs_busy !== 1'b1) begin errors++; $display("FAIL post_reset_one_issue got %b exp 1", rs_busy); end
    we = 1'b1; wb_addr = 4'd3; wb = 16'h6666;
    #1;
    checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL post_reset_last_wb got %b exp 0", rs_busy); end
    tick();
    we = 1'b0;
    #1;
    checks++; if (rs_busy !== 1'b0 || rs_data !== 16'h6666) begin errors++; $display("FAIL post_reset_drained got busy=%b data=%h exp busy=0 data=6666", rs_busy, rs_data); end
  endtask

  task automatic test_write_bypass();
    idle();
    we = 1'b1; wb_addr = 4'd5; wb = 16'hBEEF; rs_addr = 4'd5;
    #1;
    checks++; if (rs_data !== 16'hBEEF) begin errors++; $display("FAIL bypass_same_cycle got %h exp beef", rs_data); end
    tick();
    we = 1'b0; rt_addr = 4'd5;
    #1;
    checks++; if (rs_data !== 16'hBEEF) begin errors++; $display("FAIL stored_next_cycle got %h exp beef", rs_data); end
    checks++; if (rt_data !== 16'hBEEF) begin errors++; $display("FAIL stored_rt_port got %h exp beef", rt_data); end
  endtask

  task automatic test_r0_r15();
    idle();
    we = 1'b1; wb_addr = 4'd0; wb = 16'hFFFF; rs_addr = 4'd0;
    #1;
    checks++; if (rs_data !== 16'h0) begin errors++; $display("FAIL r0_bypass got %h exp 0000", rs_data); end
    tick();
    we = 1'b1; wb_addr = 4'hF; wb = 16'h0042;
    #1;
    checks++; if (rs_data !== 16'h0) begin errors++; $display("FAIL r0_stored got %h exp 0000", rs_data); end
    checks++; if (ret_addr !== 16'h0042) begin errors++; $display("FAIL ret_bypass got %h exp 0042", ret_addr); end
    tick();
    we = 1'b0; rt_addr = 4'hF;
    #1;
    checks++; if (ret_addr !== 16'h0042) begin errors++; $display("FAIL ret_stored got %h exp 0042", ret_addr); end
    checks++; if (rt_data !== 16'h0042) begin errors++; $display("FAIL r15_rt got %h exp 0042", rt_data); end
  endtask

  task automatic test_scoreboard_stall();
    idle();
    issue = 1'b1; issue_addr = 4'd7; rs_addr = 4'd7;
    #1;
    checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL same_cycle_issue_busy got %b exp 0", rs_busy); end
    tick();
    tick();
    issue = 1'b0;
    #1;
    checks++; if (rs_busy !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL sb_busy got busy=%b stall=%b exp 1 1", rs_busy, stall); end
    we = 1'b1; wb_addr = 4'd7; wb = 16'h00A1;
    #1;
    checks++; if (rs_busy !== 1'b1) begin errors++; $display("FAIL sb_first_wb got %b exp 1", rs_busy); end
    tick();
    wb = 16'h00B2;
    #1;
    checks++; if (rs_busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL sb_second_wb got busy=%b stall=%b exp 0 0", rs_busy, stall); end
    checks++; if (rs_data !== 16'h00B2) begin errors++; $display("FAIL sb_second_data got %h exp 00b2", rs_data); end
    tick();
    we = 1'b0;
    #1;
    checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL sb_drained got %b exp 0", rs_busy); end
  endtask

  task automatic test_simul_issue_wb();
    idle();
    issue = 1'b1; issue_addr = 4'd4;
    tick();
    rs_addr = 4'd4; we = 1'b1; wb_addr = 4'd4; wb = 16'h4444;
    #1;
    checks++; if (rs_busy !== 1'b1) begin errors++; $display("FAIL simul_same_cycle got %b exp 1", rs_busy); end
    tick();
    issue = 1'b0; we = 1'b0;
    #1;
    checks++; if (rs_busy !== 1'b1) begin errors++; $display("FAIL simul_next_cycle got %b exp 1", rs_busy); end
    we = 1'b1;
    tick();
    we = 1'b0;
    #1;
    checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL simul_cleared got %b exp 0", rs_busy); end
  endtask

  task automatic test_overflow();
    idle();
    rt_addr = 4'd2; issue = 1'b1; issue_addr = 4'd2;
    for (int i = 0; i < 3; i++) tick();
    #1;
    checks++; if (sb_overflow !== 1'b0) begin errors++; $display("FAIL ovf_after_three got %b exp 0", sb_overflow); end
    tick();
    issue = 1'b0;
    #1;
    checks++; if (sb_overflow !== 1'b1) begin errors++; $display("FAIL ovf_after_four got %b exp 1", sb_overflow); end
    checks++; if (rt_busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b exp 1", rt_busy); end
    we = 1'b1; wb_addr = 4'd2; wb = 16'h0202;
    tick();
    tick();
    #1;
    checks++; if (rt_busy !== 1'b0) begin errors++; $display("FAIL ovf_third_wb got %b exp 0", rt_busy); end
    tick();
    we = 1'b0;
    #1;
    checks++; if (rt_busy !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", rt_busy); end
    checks++; if (sb_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", sb_overflow); end
  endtask

  task automatic test_random();
    idle();
    exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      we = 1'b0; issue = 1'b0; wb_addr = 4'd0; issue_addr = 4'd0;
      if (exp_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        we = 1'b1; wb_addr = exp_q.pop_front();
      end else if ($urandom_range(0, 9) == 0) begin
        we = 1'b1; wb_addr = 4'($urandom_range(0, 15));
      end
      wb = 16'($urandom);
      if (exp_q.size() < 5 && $urandom_range(0, 1) == 1) begin
        issue = 1'b1; issue_addr = 4'($urandom_range(0, 15));
        if (issue_addr != 4'd0) exp_q.push_back(issue_addr);
      end
      rs_addr = 4'($urandom_range(0, 15));
      rt_addr = 4'($urandom_range(0, 15));
      #1;
      checks++; if (rs_data !== exp_rd(rs_addr)) begin errors++; $display("FAIL rnd_rs_data got %h exp %h", rs_data, exp_rd(rs_addr)); end
      checks++; if (rt_data !== exp_rd(rt_addr)) begin errors++; $display("FAIL rnd_rt_data got %h exp %h", rt_data, exp_rd(rt_addr)); end
      checks++; if (ret_addr !== exp_rd(4'hF)) begin errors++; $display("FAIL rnd_ret_addr got %h exp %h", ret_addr, exp_rd(4'hF)); end
      checks++; if (rs_busy !== exp_busy(rs_addr)) begin errors++; $display("FAIL rnd_rs_busy got %b exp %b", rs_busy, exp_busy(rs_addr)); end
      checks++; if (rt_busy !== exp_busy(rt_addr)) begin errors++; $display("FAIL rnd_rt_busy got %b exp %b", rt_busy, exp_busy(rt_addr)); end
      checks++; if (stall !== (exp_busy(rs_addr) | exp_busy(rt_addr))) begin errors++; $display("FAIL rnd_stall got %b", stall); end
      checks++; if (sb_overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow got %b exp %b", sb_overflow, m_ovf); end
      tick();
    end
  endtask

  task automatic test_final_reset();
    idle();
    #1 rst = 1'b1; m_reset();
    #1;
    checks++; if (sb_overflow !== 1'b0) begin errors++; $display("FAIL final_reset_ovf got %b exp 0", sb_overflow); end
    tick();
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rs_addr = 4'(a);
      #1;
      checks++; if (rs_busy !== 1'b0 || rs_data !== 16'h0) begin errors++; $display("FAIL final_reset_reg%0d got busy=%b data=%h exp 0 0000", a, rs_busy, rs_data); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_reset();
    tick();
    tick();
    rst = 1'b0;
    #1;
    test_reset();
    test_write_bypass();
    test_r0_r15();
    test_scoreboard_stall();
    test_simul_issue_wb();
    test_overflow();
    test_random();
    test_final_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
